duty_button_ctrl: RTL
=====================

DUTY_BUTTON_CTRL -- requirements
Module: duty_button_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 4: clk cycles per sample tick (>=2).
REQ-002 SHALL have parameter DEB_TICKS, default 3: consecutive disagreeing ticks needed to flip a debounced level (1..255).
REQ-003 SHALL have parameter HOLD_TICKS, default 8: ticks from accepted press to first auto-repeat pulse (1..255).
REQ-004 SHALL have parameter REPEAT_TICKS, default 2: ticks between subsequent auto-repeat pulses (1..255).
REQ-005 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port ena  input  1  block enable; low forces idle.
REQ-008 SHALL have port btn_inc  input  1  raw asynchronous increase button, active-high.
REQ-009 SHALL have port btn_dec  input  1  raw asynchronous decrease button, active-high.
REQ-010 SHALL have port inc_pulse  output  1  one-cycle request to raise duty cycle one step.
REQ-011 SHALL have port dec_pulse  output  1  one-cycle request to lower duty cycle one step.
REQ-012 SHALL have port inc_level, dec_level  output  1 each  debounced button levels.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer; debounce logic sees only the second flop.
REQ-014 SHALL run one shared tick counter 0..TICK_DIV-1, asserting tick for one cycle when count = TICK_DIV-1, then wrapping to 0.
REQ-015 SHALL, per channel on each tick: clear the debounce counter if the synchronized level equals the debounced level, else increment it; on reaching DEB_TICKS, toggle the debounced level and clear the counter.
REQ-016 SHALL leave the debounce counter and debounced level unchanged on non-tick cycles.
REQ-017 SHALL implement per-channel FSM states IDLE, HOLD, REPEAT.
REQ-018 IDLE -> HOLD when debounced level rises: emit one pulse, load repeat counter with HOLD_TICKS.
REQ-019 HOLD/REPEAT: decrement repeat counter on each tick; on reaching 0, emit one pulse, reload REPEAT_TICKS, enter/stay REPEAT.
REQ-020 Any state -> IDLE when debounced level falls; no pulse on release.
REQ-021 SHALL register pulses: each is high exactly one clk cycle, the cycle after the triggering event.
REQ-022 SHALL suppress inc_pulse while dec_level is high, and dec_pulse while inc_level is high; simultaneous channel pulses produce no output.
REQ-023 SHALL, while ena is low, hold both FSMs in IDLE and both pulses low; debounce continues, so a button already held when ena rises produces no pulse until released and re-pressed.
REQ-024 SHALL never assert inc_pulse and dec_pulse in the same cycle.
REQ-025 Counters SHALL be sized to parameter maxima with no overflow or wrap other than the tick counter.

Reset
REQ-026 rst high SHALL asynchronously clear synchronizers, tick counter, debounce counters, repeat counters, debounced levels, and all outputs to 0, with FSMs in IDLE.
REQ-027 Reset mid-hold SHALL abort the repeat sequence; after release a still-held button SHALL need DEB_TICKS ticks before its first pulse.

Structure
REQ-028 SHALL place FSM state encoding and parameter defaults in shared package duty_ctrl_pkg.
REQ-029 SHALL instantiate sub-module btn_channel twice (synchronizer, debounce, FSM, repeat counter); the top holds the tick counter, interlock and enable gating.

Verification
REQ-030 Defaults, btn_inc high for 20 cycles -> exactly one inc_pulse, no later than cycle 16 after the edge.
REQ-031 btn_inc glitch high for 5 cycles -> no pulse; inc_level stays 0.
REQ-032 btn_inc held 100 cycles -> first pulse, second 32 cycles later, then every 8 cycles; none after debounced release.
REQ-033 btn_inc and btn_dec rise in the same cycle and are held -> zero pulses on both outputs.
REQ-034 ena low, btn_dec held 40 cycles, ena raised -> no dec_pulse until release and re-press.
REQ-035 rst pulsed during REPEAT -> all outputs 0 immediately; button still held -> first pulse is a fresh press (debounce, then HOLD_TICKS before repeats).

Source files
------------

// File: rtl/duty_ctrl_pkg.sv
// rtl/duty_ctrl_pkg.sv - shared state encoding and parameter defaults for duty_button_ctrl
// Purpose: per-channel FSM state type, default timing parameters, counter width.
// Ports: none (package).
package duty_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } chan_state_t;

  localparam int DEF_TICK_DIV     = 4;
  localparam int DEF_DEB_TICKS    = 3;
  localparam int DEF_HOLD_TICKS   = 8;
  localparam int DEF_REPEAT_TICKS = 2;

  // Debounce and repeat counters only ever hold values up to 255.
  localparam int CNT_W = 8;

endpackage

// File: rtl/btn_channel.sv
// rtl/btn_channel.sv - one button channel: synchronizer, debounce, press/auto-repeat FSM
// Purpose: turns a raw asynchronous button into a debounced level and single-cycle
//          fire strobes (press, then auto-repeat after a hold delay).
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   tick      - shared sample strobe from the top
//   en        - enable; low keeps the FSM idle (debounce keeps running)
//   btn       - raw asynchronous button
//   level     - debounced button level
//   fire      - combinational strobe, registered by the top into a pulse
module btn_channel
  import duty_ctrl_pkg::*;
#(
  parameter int DEB_TICKS    = DEF_DEB_TICKS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic en,
  input  logic btn,
  output logic level,
  output logic fire
);

  logic             sync1, sync2;
  logic [CNT_W-1:0] deb_cnt;
  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_next;
  logic             flip, rise, fall;
  chan_state_t      state, state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // The debounced level flips on the tick whose disagreement count reaches
  // DEB_TICKS; rise/fall are therefore aligned to that tick.
  assign flip = tick && (sync2 != level) && (deb_cnt == CNT_W'(DEB_TICKS - 1));
  assign rise = flip && !level;
  assign fall = flip && level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_cnt <= '0;
      level   <= 1'b0;
    end else if (tick) begin
      if (sync2 == level) begin
        deb_cnt <= '0;
      end else if (flip) begin
        deb_cnt <= '0;
        level   <= ~level;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rpt_cnt <= '0;
    end else begin
      state   <= state_next;
      rpt_cnt <= rpt_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    rpt_cnt_next = rpt_cnt;
    fire         = 1'b0;
    if (!en || fall) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state_next   = ST_HOLD;
            rpt_cnt_next = CNT_W'(HOLD_TICKS);
            fire         = 1'b1;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          if (tick) begin
            // A count of 1 is the tick on which the counter would reach zero.
            if (rpt_cnt == CNT_W'(1)) begin
              state_next   = ST_REPEAT;
              rpt_cnt_next = CNT_W'(REPEAT_TICKS);
              fire         = 1'b1;
            end else begin
              rpt_cnt_next = rpt_cnt - 1'b1;
            end
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/duty_button_ctrl.sv
// rtl/duty_button_ctrl.sv - two-button duty-cycle step controller with debounce and auto-repeat
// Purpose: shared sample tick, two button channels, inc/dec interlock, enable gating.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   ena                  - block enable
//   btn_inc, btn_dec     - raw asynchronous buttons, active-high
//   inc_pulse, dec_pulse - one-cycle step requests, never both high
//   inc_level, dec_level - debounced button levels
module duty_button_ctrl
  import duty_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int DEB_TICKS    = DEF_DEB_TICKS,
  parameter int HOLD_TICKS   = DEF_HOLD_TICKS,
  parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic btn_inc,
  input  logic btn_dec,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic inc_level,
  output logic dec_level
);

  localparam int TICK_W = $clog2(TICK_DIV);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              inc_fire, dec_fire;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  btn_channel #(
    .DEB_TICKS   (DEB_TICKS),
    .HOLD_TICKS  (HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) u_inc (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .en   (ena),
    .btn  (btn_inc),
    .level(inc_level),
    .fire (inc_fire)
  );

  btn_channel #(
    .DEB_TICKS   (DEB_TICKS),
    .HOLD_TICKS  (HOLD_TICKS),
    .REPEAT_TICKS(REPEAT_TICKS)
  ) u_dec (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .en   (ena),
    .btn  (btn_dec),
    .level(dec_level),
    .fire (dec_fire)
  );

  // A channel is muted while the opposite button is held, and simultaneous
  // fires cancel, so the two pulses can never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
    end else begin
      inc_pulse <= ena && inc_fire && !dec_fire && !dec_level;
      dec_pulse <= ena && dec_fire && !inc_fire && !inc_level;
    end
  end

endmodule
